// File: rtl/keypad_pkg.sv
// Shared constants, FSM/frame-class encodings and the frame classifier for the keypad scanner.
package keypad_pkg;

    localparam int KEY_W   = 4;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int ENTRY_W = 4 * KEY_W;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [1:0] CLS_NONE   = 2'd0;
    localparam logic [1:0] CLS_SINGLE = 2'd1;
    localparam logic [1:0] CLS_MULTI  = 2'd2;

    typedef struct packed {
        logic [1:0]       cls;
        logic [KEY_W-1:0] code;
    } frame_class_t;

    // hits[row*COLS+col] is high where that intersection was seen pressed during the frame.
    function automatic frame_class_t classify_frame(input logic [ROWS*COLS-1:0] hits);
        frame_class_t res;
        logic [4:0]   n;
        res.cls  = CLS_NONE;
        res.code = '0;
        n        = '0;
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (hits[i]) begin
                n        = n + 5'd1;
                res.code = KEY_W'(i);
            end
        end
        if (n == 5'd1) begin
            res.cls = CLS_SINGLE;
        end else if (n > 5'd1) begin
            res.cls = CLS_MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column scan timing: dwell counter, column index, active-low column drive and
// the dwell-end / frame-end strobes.
module keypad_scan_timer
    import keypad_pkg::*;
#(
    parameter int SCAN_TICK = 100_000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            dwell_end,
    output logic            frame_end,
    output logic [1:0]      col_idx,
    output logic [COLS-1:0] col_out
);

    localparam int TICK_W = (SCAN_TICK > 1) ? $clog2(SCAN_TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICK - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [COLS-1:0]   col_out_q, col_out_d;

    assign dwell_end = (tick_q == TICK_LAST);
    assign frame_end = dwell_end && (col_idx_q == 2'(COLS - 1));
    assign col_idx   = col_idx_q;
    assign col_out   = col_out_q;

    // col_out is registered from the next index so it switches on the same edge as col_idx.
    always_comb begin
        tick_d    = tick_q + TICK_W'(1);
        col_idx_d = col_idx_q;
        if (dwell_end) begin
            tick_d    = '0;
            col_idx_d = col_idx_q + 2'd1;
        end
        col_out_d = ~(COLS'(1) << col_idx_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q    <= '0;
            col_idx_q <= '0;
            col_out_q <= 4'b1110;
        end else begin
            tick_q    <= tick_d;
            col_idx_q <= col_idx_d;
            col_out_q <= col_out_d;
        end
    end

endmodule

// File: rtl/keypad_scanner_eep.sv
// 4x4 hex keypad scanner: synchronizes rows, classifies each scan frame, debounces
// press/release over whole frames and shifts accepted codes into a 16-bit entry word.
module keypad_scanner_eep
    import keypad_pkg::*;
#(
    parameter int SCAN_TICK       = 100_000,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ROWS-1:0]    row_in,
    input  logic               clear,
    output logic [COLS-1:0]    col_out,
    output logic [KEY_W-1:0]   key_code,
    output logic               key_valid,
    output logic               key_held,
    output logic [ENTRY_W-1:0] entry_value
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);

    logic       dwell_end;
    logic       frame_end;
    logic [1:0] col_idx;

    keypad_scan_timer #(
        .SCAN_TICK (SCAN_TICK)
    ) u_scan_timer (
        .clk       (clk),
        .reset     (reset),
        .dwell_end (dwell_end),
        .frame_end (frame_end),
        .col_idx   (col_idx),
        .col_out   (col_out)
    );

    logic [ROWS-1:0]            row_meta_q, row_meta_d;
    logic [ROWS-1:0]            row_sync_q, row_sync_d;
    logic [COLS-1:0][ROWS-1:0]  sample_q, sample_d;
    logic [COLS-1:0][ROWS-1:0]  frame_rows;
    logic [ROWS*COLS-1:0]       hits;
    frame_class_t               frame_cls;

    logic [1:0]         state_q, state_d;
    logic [KEY_W-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;
    logic [KEY_W-1:0]   key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_held_q, key_held_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_held    = key_held_q;
    assign entry_value = entry_q;

    // The last column is still being latched on the frame-end cycle, so classify it straight from the synchronizer.
    always_comb begin
        row_meta_d = row_in;
        row_sync_d = row_meta_q;
        sample_d   = sample_q;
        if (dwell_end) begin
            sample_d[col_idx] = row_sync_q;
        end
        frame_rows         = sample_q;
        frame_rows[COLS-1] = row_sync_q;
        hits               = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                hits[r*COLS + c] = ~frame_rows[c][r];
            end
        end
        frame_cls = classify_frame(hits);
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        accept      = 1'b0;
        cnt_inc     = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + CNT_W'(1);
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_cls.cls == CLS_SINGLE) begin
                        cand_d = frame_cls.code;
                        cnt_d  = CNT_ONE;
                        if (DEBOUNCE_FRAMES == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_PRESS_WAIT;
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (frame_cls.cls == CLS_SINGLE) begin
                        if (frame_cls.code == cand_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                accept = 1'b1;
                            end
                        end else begin
                            cand_d = frame_cls.code;
                            cnt_d  = CNT_ONE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (frame_cls.cls == CLS_NONE) begin
                        cnt_d = CNT_ONE;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                        end else begin
                            state_d = ST_RELEASE_WAIT;
                        end
                    end
                end
                default: begin
                    if (frame_cls.cls == CLS_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
            endcase
        end
        if (accept) begin
            state_d     = ST_PRESSED;
            key_code_d  = cand_d;
            key_held_d  = 1'b1;
            key_valid_d = 1'b1;
        end
    end

    // A clear on the same cycle as key_valid wins over the shift.
    always_comb begin
        entry_d = entry_q;
        if (clear) begin
            entry_d = '0;
        end else if (key_valid_q) begin
            entry_d = {entry_q[ENTRY_W-KEY_W-1:0], key_code_q};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q  <= '1;
            row_sync_q  <= '1;
            sample_q    <= '1;
            state_q     <= ST_IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            entry_q     <= '0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            sample_q    <= sample_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            entry_q     <= entry_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner_eep.sv
// Self-checking bench for keypad_scanner_eep: a keypad model drives the rows, a
// frame-level reference model predicts accepted keys, and a monitor scores them.
module tb_keypad_scanner_eep;

    localparam int DF = 3;

    logic        clk;
    logic        reset;
    logic [3:0]  row_in;
    logic        clear;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] entry_value;

    logic [15:0] keys;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] entry;
        longint      t;
    } exp_t;
    exp_t expQ[$];

    int          lastCls;
    int          run;
    bit          mHeld;
    logic [3:0]  mCode;
    logic [15:0] mEntry;
    bit          clearArm;

    int     validCount    = 0;
    longint lastValidTime = 0;
    longint releaseTime   = 0;
    longint pressTime     = 0;

    keypad_scanner_eep #(
        .SCAN_TICK       (4),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row_in      (row_in),
        .clear       (clear),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .entry_value (entry_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_out[c] && keys[r*4 + c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic printSummary();
        $display("%0d/%0d checks passed", nPass, nChecks);
    endtask

    // -1 = no key, -2 = several keys, otherwise the single key's code.
    function automatic int classify(input logic [15:0] m);
        int n;
        n = $countones(m);
        if (n == 0) return -1;
        if (n > 1) return -2;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) return i;
        end
        return -2;
    endfunction

    task automatic modelReset();
        lastCls = -3;
        run     = 0;
        mHeld   = 1'b0;
        mCode   = 4'h0;
        mEntry  = 16'h0000;
    endtask

    // A press is accepted when the run of identical single-key frames reaches DF while
    // nothing is held; a release when the run of empty frames reaches DF while held.
    task automatic modelFrame(input logic [15:0] m, output bit accepted);
        int   cls;
        exp_t e;
        accepted = 1'b0;
        cls = classify(m);
        if (cls == lastCls) begin
            run++;
        end else begin
            run     = 1;
            lastCls = cls;
        end
        if (!mHeld && cls >= 0 && run == DF) begin
            mHeld  = 1'b1;
            mCode  = 4'(cls);
            mEntry = clearArm ? 16'h0000 : {mEntry[11:0], mCode};
            e.code  = mCode;
            e.entry = mEntry;
            e.t     = $time;
            expQ.push_back(e);
            accepted = 1'b1;
        end else if (mHeld && cls == -1 && run == DF) begin
            mHeld = 1'b0;
        end
    endtask

    task automatic nextFrame();
        logic [3:0] prev;
        bit         found;
        bit         accepted;
        prev  = col_out;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            clear = 1'b0;
            if (prev == 4'b0111 && col_out == 4'b1110) found = 1'b1;
            prev = col_out;
        end
        if (!found) begin
            nChecks++;
            $display("[TB] FAIL frame boundary: col_out=0x%0h, no 0111->1110 step within 40 cycles", col_out);
            printSummary();
            $fatal(1, "[TB] scan timing lost, aborting");
        end
        modelFrame(keys, accepted);
        if (accepted && clearArm) begin
            clear    = 1'b1;
            clearArm = 1'b0;
        end
        checkOutput("key_held per frame", {31'd0, key_held}, {31'd0, mHeld});
        checkOutput("key_code per frame", {28'd0, key_code}, {28'd0, mCode});
    endtask

    task automatic applyStimulus(input logic [15:0] mask, input int frames);
        keys      = mask;
        pressTime = $time;
        repeat (frames) nextFrame();
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b0;
        clear = 1'b0;
        modelReset();
        repeat (cycles) @(negedge clk);
        checkOutput("reset col_out", {28'd0, col_out}, 32'h0000_000E);
        checkOutput("reset key_valid", {31'd0, key_valid}, 32'd0);
        checkOutput("reset key_held", {31'd0, key_held}, 32'd0);
        checkOutput("reset key_code", {28'd0, key_code}, 32'd0);
        checkOutput("reset entry_value", {16'd0, entry_value}, 32'd0);
        checkOutput("no pending keys at reset", 32'(expQ.size()), 32'd0);
        reset       = 1'b1;
        releaseTime = $time;
    endtask

    task automatic doClear();
        clear  = 1'b1;
        mEntry = 16'h0000;
        nextFrame();
    endtask

    // Monitor: every key_valid pulse must match the next predicted key, arrive on the predicted cycle and last one cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset && key_valid) begin
                validCount++;
                lastValidTime = $time - 1;
                checkOutput("key_valid was predicted", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("key_valid key_code", {28'd0, key_code}, {28'd0, e.code});
                    checkOutput("key_valid timing", 32'(lastValidTime), 32'(e.t));
                    @(negedge clk);
                    #1;
                    checkOutput("key_valid pulse width", {31'd0, key_valid}, 32'd0);
                    checkOutput("entry_value after key", {16'd0, entry_value}, {16'd0, e.entry});
                end
            end
        end
    end

    initial begin
        int          v0;
        int          sel;
        int          a;
        int          b;
        logic [3:0]  expCol;
        logic [15:0] mask;

        reset    = 1'b0;
        clear    = 1'b0;
        keys     = 16'h0000;
        clearArm = 1'b0;
        modelReset();

        // 1: idle scan after reset
        doReset(3);
        checkOutput("col_out scan 0", {28'd0, col_out}, 32'h0000_000E);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            expCol = ~(4'b0001 << (k / 4));
            checkOutput("col_out scan", {28'd0, col_out}, {28'd0, expCol});
        end
        v0 = validCount;
        nextFrame();
        applyStimulus(16'h0000, 2);
        checkOutput("idle key_valid count", 32'(validCount - v0), 32'd0);
        checkOutput("idle entry_value", {16'd0, entry_value}, 32'h0000_0000);

        // 2: key 5 held 6 frames then released
        v0 = validCount;
        applyStimulus(16'h0001 << 5, 6);
        checkOutput("key5 pulse count", 32'(validCount - v0), 32'd1);
        checkOutput("key5 latency", 32'(lastValidTime - pressTime), 32'd480);
        checkOutput("key5 entry_value", {16'd0, entry_value}, 32'h0000_0005);
        applyStimulus(16'h0000, 4);
        checkOutput("key5 released", {31'd0, key_held}, 32'd0);

        // 3: keys 1, 2, 3, A then F
        applyStimulus(16'h0001 << 1, 4);
        applyStimulus(16'h0000, 4);
        applyStimulus(16'h0001 << 2, 4);
        applyStimulus(16'h0000, 4);
        applyStimulus(16'h0001 << 3, 4);
        applyStimulus(16'h0000, 4);
        applyStimulus(16'h0001 << 10, 4);
        applyStimulus(16'h0000, 4);
        checkOutput("entry after 1,2,3,A", {16'd0, entry_value}, 32'h0000_123A);
        applyStimulus(16'h0001 << 15, 4);
        applyStimulus(16'h0000, 4);
        checkOutput("entry after F", {16'd0, entry_value}, 32'h0000_23AF);

        // 4: short bounce and a two-key press are both rejected
        v0 = validCount;
        applyStimulus(16'h0001 << 7, 2);
        applyStimulus(16'h0000, 4);
        applyStimulus(16'h0021, 6);
        checkOutput("multi key_held", {31'd0, key_held}, 32'd0);
        applyStimulus(16'h0000, 4);
        checkOutput("bounce/multi pulse count", 32'(validCount - v0), 32'd0);

        // 5: reset while key 9 is held
        applyStimulus(16'h0001 << 9, 4);
        checkOutput("key9 held before reset", {31'd0, key_held}, 32'd1);
        doReset(3);
        applyStimulus(16'h0001 << 9, 4);
        checkOutput("key9 re-accept latency", 32'(lastValidTime - releaseTime), 32'd480);
        applyStimulus(16'h0000, 4);

        // 6: clear coinciding with key_valid
        doClear();
        applyStimulus(16'h0001 << 1, 4);
        applyStimulus(16'h0000, 4);
        applyStimulus(16'h0001 << 2, 4);
        applyStimulus(16'h0000, 4);
        checkOutput("entry before clear", {16'd0, entry_value}, 32'h0000_0012);
        clearArm = 1'b1;
        applyStimulus(16'h0001 << 4, 4);
        checkOutput("entry after clear+key", {16'd0, entry_value}, 32'h0000_0000);
        checkOutput("key_code after clear+key", {28'd0, key_code}, 32'h0000_0004);
        applyStimulus(16'h0000, 4);

        // Randomized key activity scored against the reference model
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                mask = 16'h0000;
            end else if (sel < 9) begin
                a    = $urandom_range(0, 15);
                mask = 16'h0001 << a;
            end else begin
                a    = $urandom_range(0, 15);
                b    = (a + $urandom_range(1, 15)) % 16;
                mask = (16'h0001 << a) | (16'h0001 << b);
            end
            applyStimulus(mask, $urandom_range(1, 5));
        end
        applyStimulus(16'h0000, 4);
        checkOutput("all predicted keys seen", 32'(expQ.size()), 32'd0);
        checkOutput("final entry_value", {16'd0, entry_value}, {16'd0, mEntry});

        printSummary();
        $finish;
    end

endmodule

// File: doc/keypad_scanner_eep.md
Name: keypad_scanner_eep

Overview:
- 4x4 hex matrix keypad scanner: the user-input counterpart of the multiplexed 7-segment display path.
- Drives keypad columns one at a time and samples the rows.
- Debounces over whole scan frames and reports each accepted key once.
- Assembles the last four keys into a 16-bit hex entry word, which feeds the EEPROM write path and the display controller's 32-bit data input.

Parameters:
- SCAN_TICK, 100_000, clk cycles per column dwell (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_FRAMES, 20, consecutive identical scan frames required to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- row_in  in  4  keypad rows; active-low, externally pulled up; asynchronous to clk.
- clear  in  1  synchronous pulse; zeroes entry_value.
- col_out  out  4  column drive; active-low, one-hot-low.
- key_code  out  4  code of the last accepted key; code = row*4 + col.
- key_valid  out  1  one-cycle pulse when a key is accepted.
- key_held  out  1  high from acceptance until the release is debounced.
- entry_value  out  16  last four accepted codes, newest in [3:0].

Behaviour:
- Reset (reset=0, asynchronous) values:
  - col_out=4'b1110, column index 0.
  - key_code=0, key_valid=0, key_held=0, entry_value=0.
  - tick counter 0, FSM in IDLE, debounce count 0.
  - synchronizer flops 4'b1111.
- Reset asserted mid-press or mid-debounce aborts everything. No key_valid is emitted when reset releases. A key still held after reset needs a full press debounce.
- Row synchronization: row_in passes through a 2-flop synchronizer before use.
- Column timing:
  - Tick counter runs 0..SCAN_TICK-1. The dwell-end event fires when the counter equals SCAN_TICK-1.
  - At dwell end, the synced rows are latched as the column sample. The column index then advances 0→1→2→3→0, and col_out becomes the inverse of one-hot(index).
- Frame end is the dwell-end event of column 3. At frame end, the four column samples are classified:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one row/column intersection low.
  - MULTI: two or more intersections low.
- FSM; all transitions occur only on frame-end cycles.
  - IDLE:
    - SINGLE(c): cand=c, cnt=1, go to PRESS_WAIT.
    - Otherwise: stay.
  - PRESS_WAIT:
    - SINGLE(cand): cnt+1. If the new count reaches DEBOUNCE_FRAMES, go to PRESSED.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI: go to IDLE.
    - With DEBOUNCE_FRAMES=1, IDLE goes directly to PRESSED on the first SINGLE frame.
  - Entry into PRESSED:
    - key_code<=cand, key_held<=1.
    - key_valid=1 for the cycle after the frame end; exactly one pulse per press.
  - PRESSED:
    - NONE: cnt=1, go to RELEASE_WAIT.
    - SINGLE or MULTI of any key: stay. No new event; rollover is ignored.
  - RELEASE_WAIT:
    - NONE: cnt+1. At DEBOUNCE_FRAMES, go to IDLE and key_held<=0.
    - Any key seen: go back to PRESSED. No new event.
- Latency: the press is accepted at frame end of frame N, where N is the DEBOUNCE_FRAMES-th consecutive stable frame. key_valid and key_code appear 1 cycle later.
- Entry register:
  - When key_valid is high, entry_value <= {entry_value[11:0], key_code}.
  - The oldest nibble is discarded on the fifth and later keys.
  - If clear coincides with key_valid, clear wins and entry_value=0; key_valid and key_code are still reported.
- cnt saturates at DEBOUNCE_FRAMES and never wraps.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state encoding (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - Frame class encoding (NONE, SINGLE, MULTI).
  - KEY_W=4, ROWS=4, COLS=4.
- One sub-module, keypad_scan_timer. It contains the tick counter, column index, col_out decode, dwell_end and frame_end strobes.
- The synchronizer, frame classifier, FSM and entry register stay in the top module.

Test Plan:
Bench uses SCAN_TICK=4 and DEBOUNCE_FRAMES=3, so one frame is 16 cycles.
1. Hold reset low, release, no keys → col_out cycles 1110, 1101, 1011, 0111 every 4 cycles. key_valid never asserts; entry_value=0x0000.
2. Key row1/col1 held 6 frames, then released → exactly one key_valid with key_code=5. Pulse comes 1 cycle after the 3rd stable frame end; entry_value=0x0005. key_held drops after 3 NONE frames.
3. Keys 1, 2, 3, A, each pressed 4 frames and released 4 frames → entry_value=0x123A. Then key F → entry_value=0x23AF.
4. Key 7 held 2 frames then released (bounce); also keys 0 and 5 held together 6 frames → no key_valid in either case; key_held stays 0.
5. Key 9 pressed, reset pulsed low mid-PRESSED while the key stays held → all outputs return to reset values. Key 9 is accepted again only 3 frames after reset release.
6. With entry_value=0x0012, pulse clear in the same cycle as key_valid for key 4 → entry_value=0x0000, key_code=4.
